// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register for the pipelined ARMv8 core, sitting directly
// after the opcode decoder. It carries the decoded control bundle and the
// ID-stage operands into EX. It also handles three control events:
//   - a load-use hazard inserts one bubble and stalls PC and IF/ID;
//   - a taken branch flush squashes the next FLUSH_DEPTH ID instructions;
//   - saturating counters track stall and flush events.
//
// Ports
//   clock, reset_n        : rising-edge clock, asynchronous active-low reset
//   id_valid              : ID holds a real instruction
//   ctl_*                 : decoder control outputs for the ID instruction
//   id_opcode             : instruction[31:21]
//   id_pc/rd1/rd2/imm     : PC, register read data, sign-extended immediate
//   id_rs1/rs2/rd         : Rn, Reg2Loc-muxed second source, destination
//   flush                 : taken branch resolved downstream
//   ex_*                  : registered copies of the above for EX
//   stall                 : combinational; holds PC and IF/ID this cycle
//   stall_count           : saturating count of stall edges
//   flush_count           : saturating count of flush edges
// ----------------------------------------------------------------------------
module id_ex_stage #(
   parameter int XLEN        = 64,
   parameter int FLUSH_DEPTH = 1,
   parameter int CNT_W       = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             id_valid,
   input  logic             ctl_alusrc,
   input  logic             ctl_memtoreg,
   input  logic             ctl_regwrite,
   input  logic             ctl_memread,
   input  logic             ctl_memwrite,
   input  logic             ctl_branch,
   input  logic             ctl_uncondbranch,
   input  logic             ctl_branchlink,
   input  logic             ctl_branchreg,
   input  logic             ctl_not_zero,
   input  logic             ctl_cb_instr,
   input  logic [1:0]       ctl_aluop,
   input  logic [10:0]      id_opcode,
   input  logic [XLEN-1:0]  id_pc,
   input  logic [XLEN-1:0]  id_rd1,
   input  logic [XLEN-1:0]  id_rd2,
   input  logic [XLEN-1:0]  id_imm,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rd,
   input  logic             flush,
   output logic             ex_valid,
   output logic             ex_alusrc,
   output logic             ex_memtoreg,
   output logic             ex_regwrite,
   output logic             ex_memread,
   output logic             ex_memwrite,
   output logic             ex_branch,
   output logic             ex_uncondbranch,
   output logic             ex_branchlink,
   output logic             ex_branchreg,
   output logic             ex_not_zero,
   output logic             ex_cb_instr,
   output logic [1:0]       ex_aluop,
   output logic [10:0]      ex_opcode,
   output logic [XLEN-1:0]  ex_pc,
   output logic [XLEN-1:0]  ex_rd1,
   output logic [XLEN-1:0]  ex_rd2,
   output logic [XLEN-1:0]  ex_imm,
   output logic [4:0]       ex_rs1,
   output logic [4:0]       ex_rs2,
   output logic [4:0]       ex_rd,
   output logic             stall,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam logic [2:0] SQUASH_RELOAD = 3'(FLUSH_DEPTH - 1);

   logic [2:0] r_squashCnt;
   logic       w_usesRs1;
   logic       w_usesRs2;
   logic       w_hazard;
   logic       w_squashing;
   logic       w_bubble;

   // Work out which source registers the ID instruction actually reads, and
   // flag a load-use hazard against a load sitting in EX. XZR (31) never
   // carries a dependence. CB-type instructions do not read Rn. B-type has
   // no second source, and stores always read Rt through the second port.
   always_comb begin
      w_usesRs1   = ~ctl_cb_instr;
      w_usesRs2   = (~ctl_alusrc & ~ctl_uncondbranch) | ctl_memwrite;
      w_hazard    = ex_valid & ex_memread & (ex_rd != 5'd31) & id_valid &
                    ((w_usesRs1 & (id_rs1 == ex_rd)) |
                     (w_usesRs2 & (id_rs2 == ex_rd)));
      w_squashing = (r_squashCnt != 3'd0);
      stall       = w_hazard & ~flush & ~w_squashing;
      w_bubble    = flush | w_squashing | stall;
   end

   // Pipeline register. A flush, an active squash window or a stall all
   // inject an all-zero bubble. Otherwise the whole ID bundle is captured.
   // A bubble after a load clears ex_memread, so a stall cannot last longer
   // than one cycle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n || w_bubble) begin
         ex_valid        <= 1'b0;
         ex_alusrc       <= 1'b0;
         ex_memtoreg     <= 1'b0;
         ex_regwrite     <= 1'b0;
         ex_memread      <= 1'b0;
         ex_memwrite     <= 1'b0;
         ex_branch       <= 1'b0;
         ex_uncondbranch <= 1'b0;
         ex_branchlink   <= 1'b0;
         ex_branchreg    <= 1'b0;
         ex_not_zero     <= 1'b0;
         ex_cb_instr     <= 1'b0;
         ex_aluop        <= 2'b00;
         ex_opcode       <= '0;
         ex_pc           <= '0;
         ex_rd1          <= '0;
         ex_rd2          <= '0;
         ex_imm          <= '0;
         ex_rs1          <= '0;
         ex_rs2          <= '0;
         ex_rd           <= '0;
      end else begin
         ex_valid        <= id_valid;
         ex_alusrc       <= ctl_alusrc;
         ex_memtoreg     <= ctl_memtoreg;
         ex_regwrite     <= ctl_regwrite;
         ex_memread      <= ctl_memread;
         ex_memwrite     <= ctl_memwrite;
         ex_branch       <= ctl_branch;
         ex_uncondbranch <= ctl_uncondbranch;
         ex_branchlink   <= ctl_branchlink;
         ex_branchreg    <= ctl_branchreg;
         ex_not_zero     <= ctl_not_zero;
         ex_cb_instr     <= ctl_cb_instr;
         ex_aluop        <= ctl_aluop;
         ex_opcode       <= id_opcode;
         ex_pc           <= id_pc;
         ex_rd1          <= id_rd1;
         ex_rd2          <= id_rd2;
         ex_imm          <= id_imm;
         ex_rs1          <= id_rs1;
         ex_rs2          <= id_rs2;
         ex_rd           <= id_rd;
      end
   end

   // Squash window. The flush edge itself produces the first bubble. The
   // counter then covers the remaining FLUSH_DEPTH-1 wrong-path
   // instructions. A new flush restarts the window instead of adding to it.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_squashCnt <= 3'd0;
      end else if (flush) begin
         r_squashCnt <= SQUASH_RELOAD;
      end else if (w_squashing) begin
         r_squashCnt <= r_squashCnt - 3'd1;
      end
   end

   // Event counters. Each one sticks at all-ones instead of wrapping.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
         end
         if (flush && (flush_count != '1)) begin
            flush_count <= flush_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_stage
// Directed bench for id_ex_stage, built with FLUSH_DEPTH=2 and CNT_W=4.
// Each scenario task drives decoded instructions and compares outputs
// against hand-computed values. Outputs are sampled 1 time unit after the
// rising edge.
// ----------------------------------------------------------------------------
module tb_id_ex_stage;

   localparam int XLEN = 64;
   localparam int CNT_W = 4;

   logic             clock;
   logic             reset_n;
   logic             id_valid;
   logic             ctl_alusrc, ctl_memtoreg, ctl_regwrite, ctl_memread;
   logic             ctl_memwrite, ctl_branch, ctl_uncondbranch;
   logic             ctl_branchlink, ctl_branchreg, ctl_not_zero, ctl_cb_instr;
   logic [1:0]       ctl_aluop;
   logic [10:0]      id_opcode;
   logic [XLEN-1:0]  id_pc, id_rd1, id_rd2, id_imm;
   logic [4:0]       id_rs1, id_rs2, id_rd;
   logic             flush;
   logic             ex_valid;
   logic             ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread;
   logic             ex_memwrite, ex_branch, ex_uncondbranch;
   logic             ex_branchlink, ex_branchreg, ex_not_zero, ex_cb_instr;
   logic [1:0]       ex_aluop;
   logic [10:0]      ex_opcode;
   logic [XLEN-1:0]  ex_pc, ex_rd1, ex_rd2, ex_imm;
   logic [4:0]       ex_rs1, ex_rs2, ex_rd;
   logic             stall;
   logic [CNT_W-1:0] stall_count, flush_count;

   int checks;
   int failures;
   int expStall;
   int expFlush;

   id_ex_stage #(.XLEN(XLEN), .FLUSH_DEPTH(2), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset_n(reset_n), .id_valid(id_valid),
      .ctl_alusrc(ctl_alusrc), .ctl_memtoreg(ctl_memtoreg),
      .ctl_regwrite(ctl_regwrite), .ctl_memread(ctl_memread),
      .ctl_memwrite(ctl_memwrite), .ctl_branch(ctl_branch),
      .ctl_uncondbranch(ctl_uncondbranch), .ctl_branchlink(ctl_branchlink),
      .ctl_branchreg(ctl_branchreg), .ctl_not_zero(ctl_not_zero),
      .ctl_cb_instr(ctl_cb_instr), .ctl_aluop(ctl_aluop),
      .id_opcode(id_opcode), .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2),
      .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .flush(flush), .ex_valid(ex_valid), .ex_alusrc(ex_alusrc),
      .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite),
      .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
      .ex_branch(ex_branch), .ex_uncondbranch(ex_uncondbranch),
      .ex_branchlink(ex_branchlink), .ex_branchreg(ex_branchreg),
      .ex_not_zero(ex_not_zero), .ex_cb_instr(ex_cb_instr),
      .ex_aluop(ex_aluop), .ex_opcode(ex_opcode), .ex_pc(ex_pc),
      .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
      .ex_rs2(ex_rs2), .ex_rd(ex_rd), .stall(stall),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   // Free-running 10-unit clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Advance one rising edge and settle just past it.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Put ID back to "no instruction", with every decoder control at zero.
   task automatic driveIdle();
      id_valid = 1'b0;
      {ctl_alusrc, ctl_memtoreg, ctl_regwrite, ctl_memread, ctl_memwrite,
       ctl_branch, ctl_uncondbranch, ctl_branchlink, ctl_branchreg,
       ctl_not_zero, ctl_cb_instr} = '0;
      ctl_aluop = 2'b00;
      id_opcode = '0;
      id_pc = '0; id_rd1 = '0; id_rd2 = '0; id_imm = '0;
      id_rs1 = '0; id_rs2 = '0; id_rd = '0;
      flush = 1'b0;
   endtask

   task automatic driveAdd(input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd);
      driveIdle();
      id_valid = 1'b1; ctl_regwrite = 1'b1; ctl_aluop = 2'b10;
      id_opcode = 11'h458;
      id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
      id_pc = 64'h1000 + 64'(rd) * 64'd4;
   endtask

   task automatic driveSub(input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd);
      driveAdd(rs1, rs2, rd);
      id_opcode = 11'h658;
   endtask

   task automatic driveLdur(input logic [4:0] rs1, input logic [4:0] rd);
      driveIdle();
      id_valid = 1'b1; ctl_alusrc = 1'b1; ctl_memtoreg = 1'b1;
      ctl_regwrite = 1'b1; ctl_memread = 1'b1;
      id_opcode = 11'h7C2;
      id_rs1 = rs1; id_rs2 = rd; id_rd = rd;
   endtask

   task automatic driveStur(input logic [4:0] rs1, input logic [4:0] rs2);
      driveIdle();
      id_valid = 1'b1; ctl_alusrc = 1'b1; ctl_memwrite = 1'b1;
      id_opcode = 11'h7C0;
      id_rs1 = rs1; id_rs2 = rs2;
   endtask

   task automatic driveB(input logic [4:0] rs2);
      driveIdle();
      id_valid = 1'b1; ctl_uncondbranch = 1'b1;
      id_opcode = 11'h0A0;
      id_rs1 = 5'd0; id_rs2 = rs2;
   endtask

   // Asynchronous reset clears captured state and counters mid-cycle. A
   // reset in the middle of a squash window leaves the stage idle.
   task automatic test_reset();
      driveIdle();
      reset_n = 1'b0;
      #12 reset_n = 1'b1;
      {ctl_alusrc, ctl_memtoreg, ctl_regwrite, ctl_memread, ctl_memwrite,
       ctl_branch, ctl_uncondbranch, ctl_branchlink, ctl_branchreg,
       ctl_not_zero, ctl_cb_instr} = '1;
      id_valid = 1'b1; ctl_aluop = '1; id_opcode = '1;
      id_pc = '1; id_rd1 = '1; id_rd2 = '1; id_imm = '1;
      id_rs1 = '1; id_rs2 = '1; id_rd = '1;
      tick();
      checks++;
      if (ex_pc !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         failures++;
         $display("[TB] FAIL capture_ones ex_pc got %h expected all-ones", ex_pc);
      end
      flush = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({ex_valid, ex_regwrite, ex_memread, ex_aluop, ex_opcode, ex_rd,
           stall} !== '0) begin
         failures++;
         $display("[TB] FAIL reset_ctl got v=%b rw=%b mr=%b op=%h rd=%0d st=%b expected 0",
                  ex_valid, ex_regwrite, ex_memread, ex_opcode, ex_rd, stall);
      end
      checks++;
      if ({ex_pc, ex_rd1, ex_rd2, ex_imm, stall_count, flush_count} !== '0) begin
         failures++;
         $display("[TB] FAIL reset_data got pc=%h imm=%h sc=%0d fc=%0d expected 0",
                  ex_pc, ex_imm, stall_count, flush_count);
      end
      #1 reset_n = 1'b1;
      tick();
      flush = 1'b0;
      #2 reset_n = 1'b0;
      #1 reset_n = 1'b1;
      driveAdd(5'd1, 5'd2, 5'd3);
      tick();
      checks++;
      if (ex_regwrite !== 1'b1 || ex_aluop !== 2'b10 || ex_rd !== 5'd3 ||
          ex_valid !== 1'b1) begin
         failures++;
         $display("[TB] FAIL add_after_reset got rw=%b aluop=%b rd=%0d v=%b expected 1 10 3 1",
                  ex_regwrite, ex_aluop, ex_rd, ex_valid);
      end
      checks++;
      if (flush_count !== 4'd0) begin
         failures++;
         $display("[TB] FAIL flush_count_after_reset got %0d expected 0", flush_count);
      end
      expStall = 0;
      expFlush = 0;
   endtask

   // LDUR X5 followed by a dependent ADD produces one stall and one bubble.
   task automatic test_load_use();
      driveLdur(5'd1, 5'd5);
      tick();
      driveAdd(5'd5, 5'd2, 5'd6);
      #1;
      checks++;
      if (stall !== 1'b1) begin
         failures++;
         $display("[TB] FAIL load_use_stall got %b expected 1", stall);
      end
      tick();
      expStall++;
      checks++;
      if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || ex_rd !== 5'd0 ||
          ex_pc !== 64'd0 || stall_count !== 4'(expStall)) begin
         failures++;
         $display("[TB] FAIL load_use_bubble got v=%b rw=%b rd=%0d pc=%h sc=%0d expected 0 0 0 0 %0d",
                  ex_valid, ex_regwrite, ex_rd, ex_pc, stall_count, expStall);
      end
      checks++;
      if (stall !== 1'b0) begin
         failures++;
         $display("[TB] FAIL stall_one_cycle got %b expected 0", stall);
      end
      tick();
      checks++;
      if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ex_aluop !== 2'b10 ||
          ex_opcode !== 11'h458 || ex_pc !== 64'h1018) begin
         failures++;
         $display("[TB] FAIL add_after_stall got v=%b rd=%0d aluop=%b op=%h pc=%h expected 1 6 10 458 1018",
                  ex_valid, ex_rd, ex_aluop, ex_opcode, ex_pc);
      end
   endtask

   // XZR and unused source fields must not stall. A store's Rt must stall.
   task automatic test_no_false_hazard();
      driveLdur(5'd1, 5'd31);
      tick();
      driveAdd(5'd31, 5'd31, 5'd2);
      #1;
      checks++;
      if (stall !== 1'b0) begin
         failures++;
         $display("[TB] FAIL xzr_no_stall got %b expected 0", stall);
      end
      tick();
      driveLdur(5'd1, 5'd7);
      tick();
      driveB(5'd7);
      #1;
      checks++;
      if (stall !== 1'b0) begin
         failures++;
         $display("[TB] FAIL branch_no_stall got %b expected 0", stall);
      end
      driveStur(5'd1, 5'd7);
      #1;
      checks++;
      if (stall !== 1'b1) begin
         failures++;
         $display("[TB] FAIL stur_rt_stall got %b expected 1", stall);
      end
      tick();
      expStall++;
      checks++;
      if (stall_count !== 4'(expStall) || ex_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL stur_stall_count got sc=%0d v=%b expected %0d 0",
                  stall_count, ex_valid, expStall);
      end
      driveIdle();
      tick();
   endtask

   // A one-cycle flush with FLUSH_DEPTH=2 squashes exactly two instructions.
   task automatic test_flush();
      driveAdd(5'd1, 5'd2, 5'd10);
      flush = 1'b1;
      tick();
      expFlush++;
      checks++;
      if (ex_valid !== 1'b0 || ex_rd !== 5'd0) begin
         failures++;
         $display("[TB] FAIL flush_bubble1 got v=%b rd=%0d expected 0 0", ex_valid, ex_rd);
      end
      driveAdd(5'd1, 5'd2, 5'd11);
      tick();
      checks++;
      if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0) begin
         failures++;
         $display("[TB] FAIL flush_bubble2 got v=%b rw=%b expected 0 0", ex_valid, ex_regwrite);
      end
      driveAdd(5'd1, 5'd2, 5'd12);
      tick();
      checks++;
      if (ex_valid !== 1'b1 || ex_rd !== 5'd12 || ex_pc !== 64'h1030) begin
         failures++;
         $display("[TB] FAIL flush_third_passes got v=%b rd=%0d pc=%h expected 1 12 1030",
                  ex_valid, ex_rd, ex_pc);
      end
      checks++;
      if (flush_count !== 4'(expFlush)) begin
         failures++;
         $display("[TB] FAIL flush_count got %0d expected %0d", flush_count, expFlush);
      end
   endtask

   // Flush and load-use hazard together: the flush wins and there is no stall.
   task automatic test_flush_hazard();
      driveLdur(5'd1, 5'd4);
      tick();
      driveSub(5'd1, 5'd4, 5'd8);
      flush = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         failures++;
         $display("[TB] FAIL flush_beats_stall got %b expected 0", stall);
      end
      tick();
      expFlush++;
      checks++;
      if (ex_valid !== 1'b0 || stall_count !== 4'(expStall) ||
          flush_count !== 4'(expFlush)) begin
         failures++;
         $display("[TB] FAIL flush_hazard_counts got v=%b sc=%0d fc=%0d expected 0 %0d %0d",
                  ex_valid, stall_count, flush_count, expStall, expFlush);
      end
      driveIdle();
      tick();
      tick();
   endtask

   // Twenty more stall events drive the 4-bit stall counter to its ceiling.
   task automatic test_saturation();
      for (int i = 0; i < 20; i++) begin
         driveLdur(5'd1, 5'd5);
         tick();
         driveAdd(5'd5, 5'd5, 5'd9);
         tick();
         if (expStall < 15) expStall++;
         driveIdle();
         tick();
      end
      checks++;
      if (stall_count !== 4'hF || expStall != 15) begin
         failures++;
         $display("[TB] FAIL stall_saturate got %0d expected 15", stall_count);
      end
      checks++;
      if (flush_count !== 4'(expFlush)) begin
         failures++;
         $display("[TB] FAIL flush_count_stable got %0d expected %0d", flush_count, expFlush);
      end
   endtask

   // Run every scenario in order, then print the summary line.
   initial begin
      checks = 0;
      failures = 0;
      expStall = 0;
      expFlush = 0;
      test_reset();
      test_load_use();
      test_no_false_hazard();
      test_flush();
      test_flush_hazard();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
